// File: rtl/pack_pkg.sv
// Shared definitions for the packet-word path: word width, default packet size, sync bytes.
package pack_pkg;
    localparam int PKT_WORD_W        = 16;
    localparam int WORDS_PER_PKT_DEF = 8;
    localparam logic [7:0] SYNC_BYTE_HI = 8'hFF;
    localparam logic [7:0] SYNC_BYTE_LO = 8'h7F;
endpackage

// File: rtl/rr_pick.sv
// Combinational winner select: lowest set request when fixed, else first set after 'last'.
module rr_pick #(
    parameter int NUM_SRC = 2,
    parameter int SRC_W   = 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   last,
    input  logic               fixed,
    output logic [SRC_W-1:0]   winner,
    output logic               any
);
    logic found;
    int   idx;

    // Round-robin scan starts one past 'last', so 'last' is the final candidate.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = fixed ? k : (int'(last) + 1 + k) % NUM_SRC;
            if (!found && req[idx[SRC_W-1:0]]) begin
                winner = SRC_W'(idx);
                found  = 1'b1;
            end
        end
    end

    assign any = |req;
endmodule

// File: rtl/pack_src_arbiter.sv
// Shares one packet-word consumer among NUM_SRC packetizers; grants change only on PacketNext.
// Strobes route to sources with zero latency; PacketAvail is registered (one cycle).
module pack_src_arbiter
    import pack_pkg::*;
#(
    parameter int NUM_SRC       = 2,
    parameter int SRC_W         = 1,
    parameter int WORDS_PER_PKT = WORDS_PER_PKT_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          FixedPri,
    input  logic [NUM_SRC-1:0]            SrcAvail,
    output logic [NUM_SRC-1:0]            SrcNext,
    output logic [NUM_SRC-1:0]            SrcNextWd,
    input  logic [PKT_WORD_W*NUM_SRC-1:0] SrcData,
    output logic                          PacketAvail,
    input  logic                          PacketNext,
    input  logic                          PacketNextWd,
    output logic [PKT_WORD_W-1:0]         PacketIn,
    output logic [SRC_W-1:0]              SrcId,
    output logic                          Busy,
    output logic                          WordOvr,
    output logic                          NoPktErr
);
    localparam int CNT_W = $clog2(WORDS_PER_PKT + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_PKT + 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WORDS_PER_PKT + 2);

    logic [SRC_W-1:0] grant_q, grant_d, last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d, ovr_q, ovr_d, nopkt_q, nopkt_d, avail_q, avail_d;
    logic [SRC_W-1:0] winner;
    logic             any, take, wd_fwd;

    rr_pick #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) u_pick (
        .req    (SrcAvail),
        .last   (last_q),
        .fixed  (FixedPri),
        .winner (winner),
        .any    (any)
    );

    // A packet strobe in the same cycle masks the word strobe entirely.
    assign take   = PacketNext & any & ~rst;
    assign wd_fwd = PacketNextWd & busy_q & ~PacketNext & ~rst;

    always_comb begin
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        ovr_d   = ovr_q;
        nopkt_d = nopkt_q;
        avail_d = |SrcAvail;
        if (PacketNext) begin
            cnt_d = '0;
            if (any) begin
                grant_d = winner;
                last_d  = winner;
                busy_d  = 1'b1;
            end else begin
                nopkt_d = 1'b1;
            end
        end else if (wd_fwd) begin
            if (cnt_q >= CNT_LAST) ovr_d = 1'b1;
            if (cnt_q != CNT_SAT)  cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q <= '0;
            last_q  <= SRC_W'(NUM_SRC - 1);
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            nopkt_q <= 1'b0;
            avail_q <= 1'b0;
        end else begin
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
            nopkt_q <= nopkt_d;
            avail_q <= avail_d;
        end
    end

    assign SrcNext     = take   ? (NUM_SRC'(1) << winner)  : '0;
    assign SrcNextWd   = wd_fwd ? (NUM_SRC'(1) << grant_q) : '0;
    assign PacketIn    = busy_q ? SrcData[int'(grant_q)*PKT_WORD_W +: PKT_WORD_W] : '0;
    assign PacketAvail = avail_q;
    assign SrcId       = grant_q;
    assign Busy        = busy_q;
    assign WordOvr     = ovr_q;
    assign NoPktErr    = nopkt_q;
endmodule

// File: tb/tb_pack_src_arbiter.sv
// Directed bench: expected strobes are queued by stimulus and matched by a negedge monitor.
module tb_pack_src_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        FixedPri;
    logic [1:0]  SrcAvail;
    logic [1:0]  SrcNext, SrcNextWd;
    logic [31:0] SrcData;
    logic        PacketAvail, PacketNext, PacketNextWd;
    logic [15:0] PacketIn;
    logic        SrcId, Busy, WordOvr, NoPktErr;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  nxt;
        logic [1:0]  wd;
        logic [15:0] pin;
        logic        chk_pin;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    pack_src_arbiter #(.NUM_SRC(2), .SRC_W(1), .WORDS_PER_PKT(8)) dut (
        .clk(clk), .rst(rst), .FixedPri(FixedPri), .SrcAvail(SrcAvail),
        .SrcNext(SrcNext), .SrcNextWd(SrcNextWd), .SrcData(SrcData),
        .PacketAvail(PacketAvail), .PacketNext(PacketNext), .PacketNextWd(PacketNextWd),
        .PacketIn(PacketIn), .SrcId(SrcId), .Busy(Busy), .WordOvr(WordOvr), .NoPktErr(NoPktErr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] nxt, input logic [1:0] wd,
                        input logic [15:0] pin, input logic chk_pin);
        exp_t e;
        e.nxt = nxt; e.wd = wd; e.pin = pin; e.chk_pin = chk_pin;
        exp_q.push_back(e);
    endtask

    // Entered and left at posedge+1: drives strobes for exactly one cycle.
    task automatic cyc(input logic nx, input logic wd);
        PacketNext   = nx;
        PacketNextWd = wd;
        @(posedge clk); #1;
        PacketNext   = 1'b0;
        PacketNextWd = 1'b0;
    endtask

    // Monitor: any strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (SrcNext != 2'b00 || SrcNextWd != 2'b00) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_strobe: got next=%b wd=%b expected none", SrcNext, SrcNextWd);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_SrcNext", 32'(SrcNext), 32'(e.nxt));
                chk("sb_SrcNextWd", 32'(SrcNextWd), 32'(e.wd));
                if (e.chk_pin) chk("sb_PacketIn", 32'(PacketIn), 32'(e.pin));
            end
        end
    end

    initial begin
        rst = 1'b1; FixedPri = 1'b0; SrcAvail = 2'b11; SrcData = {16'hA55A, 16'h1234};
        PacketNext = 1'b1; PacketNextWd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; PacketNext = 1'b0;
        chk("rst_Busy", 32'(Busy), 0);
        chk("rst_SrcId", 32'(SrcId), 0);
        chk("rst_WordOvr", 32'(WordOvr), 0);
        chk("rst_NoPktErr", 32'(NoPktErr), 0);
        chk("rst_PacketAvail", 32'(PacketAvail), 0);
        chk("rst_PacketIn", 32'(PacketIn), 0);
        cyc(1'b0, 1'b0);
        chk("avail_latency", 32'(PacketAvail), 1);

        // Round-robin from reset: 0, 1, 0
        push(2'b01, 2'b00, 16'h0, 1'b0); cyc(1'b1, 1'b0);
        chk("rr1_SrcId", 32'(SrcId), 0);
        chk("rr1_Busy", 32'(Busy), 1);
        push(2'b10, 2'b00, 16'h0, 1'b0); cyc(1'b1, 1'b0);
        chk("rr2_SrcId", 32'(SrcId), 1);
        push(2'b01, 2'b00, 16'h0, 1'b0); cyc(1'b1, 1'b0);
        chk("rr3_SrcId", 32'(SrcId), 0);

        FixedPri = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(2'b01, 2'b00, 16'h0, 1'b0); cyc(1'b1, 1'b0);
            chk("fix_SrcId", 32'(SrcId), 0);
        end
        chk("fix_NoPktErr", 32'(NoPktErr), 0);

        // Source 1 owns a packet; its request drops mid-packet
        SrcAvail = 2'b10;
        push(2'b10, 2'b00, 16'h0, 1'b0); cyc(1'b1, 1'b0);
        chk("g1_SrcId", 32'(SrcId), 1);
        chk("g1_PacketIn", 32'(PacketIn), 32'hA55A);
        SrcAvail = 2'b00;
        for (int i = 0; i < 9; i++) begin
            push(2'b00, 2'b10, 16'hA55A, 1'b1); cyc(1'b0, 1'b1);
        end
        chk("nine_WordOvr", 32'(WordOvr), 0);
        chk("nine_SrcId", 32'(SrcId), 1);
        push(2'b00, 2'b10, 16'hA55A, 1'b1); cyc(1'b0, 1'b1);
        chk("tenth_WordOvr", 32'(WordOvr), 1);

        // PacketNext with nothing available
        cyc(1'b1, 1'b0);
        chk("nopkt_NoPktErr", 32'(NoPktErr), 1);
        chk("nopkt_SrcId", 32'(SrcId), 1);
        chk("nopkt_Busy", 32'(Busy), 1);
        chk("nopkt_WordOvr", 32'(WordOvr), 1);
        push(2'b00, 2'b10, 16'hA55A, 1'b1); cyc(1'b0, 1'b1);
        chk("late_WordOvr", 32'(WordOvr), 1);

        // lastGrant = 1 wraps to source 0; reset mid-packet
        FixedPri = 1'b0; SrcAvail = 2'b11;
        push(2'b01, 2'b00, 16'h0, 1'b0); cyc(1'b1, 1'b0);
        chk("wrap_SrcId", 32'(SrcId), 0);
        for (int i = 0; i < 4; i++) begin
            push(2'b00, 2'b01, 16'h1234, 1'b1); cyc(1'b0, 1'b1);
        end
        rst = 1'b1; PacketNextWd = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; PacketNextWd = 1'b0;
        chk("mrst_Busy", 32'(Busy), 0);
        chk("mrst_SrcId", 32'(SrcId), 0);
        chk("mrst_WordOvr", 32'(WordOvr), 0);
        chk("mrst_NoPktErr", 32'(NoPktErr), 0);
        chk("mrst_PacketAvail", 32'(PacketAvail), 0);
        chk("mrst_PacketIn", 32'(PacketIn), 0);
        cyc(1'b0, 1'b1);
        chk("idle_wd_WordOvr", 32'(WordOvr), 0);

        // Packet and word strobe together: only the packet strobe fires
        push(2'b01, 2'b00, 16'h0, 1'b0); cyc(1'b1, 1'b1);
        chk("both_SrcId", 32'(SrcId), 0);
        chk("both_Busy", 32'(Busy), 1);
        chk("both_WordOvr", 32'(WordOvr), 0);
        push(2'b10, 2'b00, 16'h0, 1'b0); cyc(1'b1, 1'b0);
        chk("post_SrcId", 32'(SrcId), 1);
        chk("post_PacketAvail", 32'(PacketAvail), 1);

        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
